// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the regfile write port, with a flush sequencer that zeroes every register.
// Latency: 1 cycle from request (or flush step) to registered rf_* outputs. Backpressure: requesters hold valid until acked; a flush stalls all requesters.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2,
    parameter int DATA_W  = 8
) (
    input  logic                        clock,
    input  logic                        clear_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*IDX_W-1:0]    req_index,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ack,
    input  logic                        flush_req,
    output logic                        busy,
    output logic                        flush_done,
    output logic                        rf_write,
    output logic [IDX_W-1:0]            rf_write_index,
    output logic [DATA_W-1:0]           rf_write_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_q, rr_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic                rf_write_q, rf_write_d;
    logic [IDX_W-1:0]    rf_index_q, rf_index_d;
    logic [DATA_W-1:0]   rf_data_q, rf_data_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [NUM_REQ-1:0]  eligible;
    logic                grant_found;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W:0]      cand;

    always_comb begin
        // A requester acked this cycle still shows valid; mask it so it is not granted twice.
        eligible    = req_valid & ~ack_q;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && eligible[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        rf_write_d = 1'b0;
        rf_index_d = rf_index_q;
        rf_data_d  = rf_data_q;
        ack_d      = '0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else if (grant_found) begin
                    rf_write_d       = 1'b1;
                    ack_d[grant_idx] = 1'b1;
                    rf_index_d       = req_index[grant_idx*IDX_W +: IDX_W];
                    rf_data_d        = req_data[grant_idx*DATA_W +: DATA_W];
                    if (grant_idx == PTR_W'(NUM_REQ-1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = grant_idx + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                rf_write_d = 1'b1;
                rf_index_d = cnt_q;
                rf_data_d  = '0;
                busy_d     = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= ST_IDLE;
            rr_q       <= '0;
            cnt_q      <= '0;
            rf_write_q <= 1'b0;
            rf_index_q <= '0;
            rf_data_q  <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            rf_write_q <= rf_write_d;
            rf_index_q <= rf_index_d;
            rf_data_q  <= rf_data_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign req_ack        = ack_q;
    assign busy           = busy_q;
    assign flush_done     = done_q;
    assign rf_write       = rf_write_q;
    assign rf_write_index = rf_index_q;
    assign rf_write_data  = rf_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: expected port writes queued at stimulus time, compared as they appear.
module tb_regfile_write_arbiter;

    logic        clock;
    logic        clear_n;
    logic [2:0]  req_valid;
    logic [5:0]  req_index;
    logic [23:0] req_data;
    logic [2:0]  req_ack;
    logic        flush_req;
    logic        busy;
    logic        flush_done;
    logic        rf_write;
    logic [1:0]  rf_write_index;
    logic [7:0]  rf_write_data;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] dat;
        logic [2:0] ack;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] regs [4];
    int         checks = 0;
    int         errors = 0;

    regfile_write_arbiter #(.NUM_REQ(3), .IDX_W(2), .DATA_W(8)) dut (
        .clock          (clock),
        .clear_n        (clear_n),
        .req_valid      (req_valid),
        .req_index      (req_index),
        .req_data       (req_data),
        .req_ack        (req_ack),
        .flush_req      (flush_req),
        .busy           (busy),
        .flush_done     (flush_done),
        .rf_write       (rf_write),
        .rf_write_index (rf_write_index),
        .rf_write_data  (rf_write_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Regfile model commits mid-cycle; scoreboard compares each write as it lands.
    always @(negedge clock) begin
        if (clear_n && rf_write) begin
            regs[rf_write_index] = rf_write_data;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write got idx=%0d data=%h ack=%b", rf_write_index, rf_write_data, req_ack);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (rf_write_index !== e.idx || rf_write_data !== e.dat || req_ack !== e.ack) begin
                    errors++;
                    $display("FAIL sb_write got idx=%0d data=%h ack=%b want idx=%0d data=%h ack=%b",
                             rf_write_index, rf_write_data, req_ack, e.idx, e.dat, e.ack);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] idx, input logic [7:0] dat);
        req_index[i*2 +: 2] = idx;
        req_data[i*8 +: 8]  = dat;
    endtask

    task automatic push(input logic [1:0] idx, input logic [7:0] dat, input logic [2:0] ack);
        exp_t e;
        e.idx = idx;
        e.dat = dat;
        e.ack = ack;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        clear_n   = 1'b0;
        flush_req = 1'b0;
        req_valid = 3'b111;
        set_req(0, 2'd3, 8'h11);
        set_req(1, 2'd1, 8'h22);
        set_req(2, 2'd0, 8'h33);
        repeat (3) tick();
        checks++;
        if (rf_write !== 1'b0 || req_ack !== 3'b000 || busy !== 1'b0 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got wr=%b ack=%b busy=%b done=%b want 0", rf_write, req_ack, busy, flush_done);
        end
        clear_n = 1'b1;
        push(2'd3, 8'h11, 3'b001);
        tick();
        checks++;
        if (req_ack !== 3'b001) begin
            errors++;
            $display("FAIL first_grant got ack=%b want 001", req_ack);
        end
        req_valid = 3'b000;
        tick();
        checks++;
        if (rf_write !== 1'b0 || rf_write_index !== 2'd3 || rf_write_data !== 8'h11) begin
            errors++;
            $display("FAIL idle_hold got wr=%b idx=%0d data=%h want 0/3/11", rf_write, rf_write_index, rf_write_data);
        end
    endtask

    task automatic test_single();
        set_req(1, 2'd2, 8'hA5);
        req_valid = 3'b010;
        push(2'd2, 8'hA5, 3'b010);
        tick();
        checks++;
        if (rf_write !== 1'b1 || req_ack !== 3'b010) begin
            errors++;
            $display("FAIL single_grant got wr=%b ack=%b want 1/010", rf_write, req_ack);
        end
        req_valid = 3'b000;
        tick();
        checks++;
        if (regs[2] !== 8'hA5) begin
            errors++;
            $display("FAIL single_reg2 got %h want a5", regs[2]);
        end
    endtask

    task automatic test_round_robin();
        int order [7] = '{2, 0, 1, 2, 0, 1, 2};
        set_req(0, 2'd0, 8'h10);
        set_req(1, 2'd1, 8'h21);
        set_req(2, 2'd2, 8'h32);
        req_valid = 3'b111;
        for (int n = 0; n < 7; n++) begin
            logic [2:0] want;
            want = 3'b001 << order[n];
            push(2'(order[n]), 8'h10 + 8'(order[n]) * 8'h11, want);
            tick();
            checks++;
            if (req_ack !== want) begin
                errors++;
                $display("FAIL rr_grant step=%0d got ack=%b want %b", n, req_ack, want);
            end
        end
    endtask

    task automatic test_wrap();
        set_req(0, 2'd3, 8'h40);
        req_valid = 3'b101;
        push(2'd3, 8'h40, 3'b001);
        tick();
        checks++;
        if (req_ack !== 3'b001) begin
            errors++;
            $display("FAIL wrap_to_0 got ack=%b want 001", req_ack);
        end
        push(2'd2, 8'h32, 3'b100);
        tick();
        checks++;
        if (req_ack !== 3'b100) begin
            errors++;
            $display("FAIL wrap_then_2 got ack=%b want 100", req_ack);
        end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_flush();
        set_req(0, 2'd1, 8'h3C);
        req_valid = 3'b001;
        flush_req = 1'b1;
        tick();
        checks++;
        if (rf_write !== 1'b0 || req_ack !== 3'b000) begin
            errors++;
            $display("FAIL flush_no_grant got wr=%b ack=%b want 0/000", rf_write, req_ack);
        end
        flush_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(2'(i), 8'h00, 3'b000);
            tick();
            checks++;
            if (busy !== 1'b1 || rf_write !== 1'b1 || req_ack !== 3'b000) begin
                errors++;
                $display("FAIL flush_step%0d got busy=%b wr=%b ack=%b want 1/1/000", i, busy, rf_write, req_ack);
            end
        end
        tick();
        checks++;
        if (flush_done !== 1'b1 || busy !== 1'b0 || rf_write !== 1'b0) begin
            errors++;
            $display("FAIL flush_done got done=%b busy=%b wr=%b want 1/0/0", flush_done, busy, rf_write);
        end
        checks++;
        if (regs[0] !== 8'h00 || regs[1] !== 8'h00 || regs[2] !== 8'h00 || regs[3] !== 8'h00) begin
            errors++;
            $display("FAIL flush_regs got %h %h %h %h want all 00", regs[0], regs[1], regs[2], regs[3]);
        end
        push(2'd1, 8'h3C, 3'b001);
        tick();
        checks++;
        if (req_ack !== 3'b001 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL post_flush_grant got ack=%b done=%b want 001/0", req_ack, flush_done);
        end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid_flush();
        set_req(1, 2'd2, 8'h77);
        req_valid = 3'b010;
        push(2'd2, 8'h77, 3'b010);
        tick();
        set_req(2, 2'd3, 8'h88);
        req_valid = 3'b100;
        push(2'd3, 8'h88, 3'b100);
        tick();
        req_valid = 3'b000;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        push(2'd0, 8'h00, 3'b000);
        tick();
        push(2'd1, 8'h00, 3'b000);
        tick();
        @(negedge clock);
        #1;
        clear_n = 1'b0;
        #1;
        checks++;
        if (rf_write !== 1'b0 || busy !== 1'b0 || req_ack !== 3'b000 ||
            rf_write_index !== 2'd0 || rf_write_data !== 8'h00) begin
            errors++;
            $display("FAIL midflush_reset got wr=%b busy=%b ack=%b idx=%0d data=%h want all 0",
                     rf_write, busy, req_ack, rf_write_index, rf_write_data);
        end
        checks++;
        if (regs[0] !== 8'h00 || regs[1] !== 8'h00 || regs[2] !== 8'h77 || regs[3] !== 8'h88) begin
            errors++;
            $display("FAIL midflush_regs got %h %h %h %h want 00 00 77 88", regs[0], regs[1], regs[2], regs[3]);
        end
        @(posedge clock);
        #1;
        clear_n   = 1'b1;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(2'(i), 8'h00, 3'b000);
            tick();
            checks++;
            if (rf_write_index !== 2'(i) || busy !== 1'b1) begin
                errors++;
                $display("FAIL restart_step%0d got idx=%0d busy=%b want %0d/1", i, rf_write_index, busy, i);
            end
        end
        tick();
        checks++;
        if (flush_done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done got done=%b want 1", flush_done);
        end
        tick();
    endtask

    initial begin
        clear_n   = 1'b0;
        req_valid = '0;
        req_index = '0;
        req_data  = '0;
        flush_req = 1'b0;
        for (int i = 0; i < 4; i++) regs[i] = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_flush();
        test_reset_mid_flush();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
